// File: rtl/lcd_win_pkg.sv
// Shared types for the LCD window controller.
// Command codes, FSM states and a width helper.
package lcd_win_pkg;

  typedef enum logic [2:0] {
    CMD_REFRESH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5,
    CMD_MIRROR  = 3'd6,
    CMD_HOME    = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OUT
  } state_e;

  // Bits needed to index v items, never less than one.
  function automatic int clog2w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/lcd_frame_mem.sv
// Frame store: one write port, one async read port.
// Whole array clears on async active-low reset.
module lcd_frame_mem
  import lcd_win_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 36,
  parameter int AW    = clog2w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next array contents: single pixel write.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lcd_win_ctrl.sv
// Loads a frame, streams a movable/mirrorable window.
// Optional cmd_err output: define LCD_WIN_CMDERR_EN.
module lcd_win_ctrl #(
  parameter int DW    = 8,
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int WIN_W = 3,
  parameter int WIN_H = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
`ifdef LCD_WIN_CMDERR_EN
  ,
  output logic          cmd_err
`endif
);

  import lcd_win_pkg::*;

  localparam int N      = IMG_W * IMG_H;
  localparam int M      = WIN_W * WIN_H;
  localparam int AW     = clog2w(N);
  localparam int CW     = clog2w(N + 1);
  localparam int OX_MAX = IMG_W - WIN_W;
  localparam int OY_MAX = IMG_H - WIN_H;
  localparam int OX_RST = (IMG_W - WIN_W + 1) / 2;
  localparam int OY_RST = (IMG_H - WIN_H + 1) / 2;
  localparam int XW     = clog2w(OX_MAX + 1);
  localparam int YW     = clog2w(OY_MAX + 1);
  localparam int CXW    = clog2w(WIN_W);
  localparam int RYW    = clog2w(WIN_H + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CXW-1:0] col_q, col_d;
  logic [RYW-1:0] row_q, row_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic          mir_q, mir_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;

  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [CW-1:0] raddr_w;
  logic [CW-1:0] xoff;
  logic [DW-1:0] rdata;

  lcd_frame_mem #(
    .DW   (DW),
    .DEPTH(N),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .rst_n(reset),
    .we   (we),
    .waddr(waddr),
    .wdata(datain),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign waddr = AW'(cnt_q);

  // Window read address; CW bits hold N so nothing wraps.
  always_comb begin
    xoff = mir_q ? (CW'(WIN_W - 1) - CW'(col_q))
                 : CW'(col_q);
    raddr_w = (CW'(oy_q) + CW'(row_q)) * CW'(IMG_W)
            + CW'(ox_q) + xoff;
    raddr = AW'(raddr_w);
  end

  // Command decode, origin update and FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    mir_d   = mir_q;
    dout_d  = '0;
    vld_d   = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = ST_OUT;
          unique case (cmd_e'(cmd))
            CMD_LOAD: state_d = ST_LOAD;
            CMD_RIGHT:
              if (ox_q != XW'(OX_MAX)) ox_d = ox_q + XW'(1);
            CMD_LEFT:
              if (ox_q != '0) ox_d = ox_q - XW'(1);
            CMD_UP:
              if (oy_q != '0) oy_d = oy_q - YW'(1);
            CMD_DOWN:
              if (oy_q != YW'(OY_MAX)) oy_d = oy_q + YW'(1);
            CMD_MIRROR: mir_d = ~mir_q;
            CMD_HOME: begin
              ox_d  = XW'(OX_RST);
              oy_d  = YW'(OY_RST);
              mir_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD: begin
        we    = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = ST_OUT;
          cnt_d   = '0;
        end
      end
      ST_OUT: begin
        if (cnt_q == CW'(M)) begin
          state_d = ST_IDLE;
        end else begin
          dout_d = rdata;
          vld_d  = 1'b1;
          cnt_d  = cnt_q + CW'(1);
          if (col_q == CXW'(WIN_W - 1)) begin
            col_d = '0;
            row_d = row_q + RYW'(1);
          end else begin
            col_d = col_q + CXW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      ox_q    <= XW'(OX_RST);
      oy_q    <= YW'(OY_RST);
      mir_q   <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      mir_q   <= mir_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign dataout      = dout_q;
  assign output_valid = vld_q;
  assign busy         = (state_q != ST_IDLE);

`ifdef LCD_WIN_CMDERR_EN
  logic err_q, err_d;

  // One-cycle flag for a command dropped while busy.
  always_comb begin
    err_d = cmd_valid && (state_q != ST_IDLE);
  end

  // Error pulse register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign cmd_err = err_q;
`endif

endmodule

// File: doc/lcd_win_ctrl.md
Name: lcd_win_ctrl

Overview:
Parametrised LCD window controller. It loads a full IMG_W x IMG_H frame of DW-bit pixels serially into internal storage, then streams a WIN_W x WIN_H sub-window in raster order to the display driver. The window can be moved, mirrored and re-homed by command. It sits between the image source and the LCD driver and is the generalised successor of the fixed 6x6/3x3 controller, adding a mirror mode and a home command.

Parameters:
DW, 8, pixel width in bits
IMG_W, 6, frame width in pixels (>= WIN_W)
IMG_H, 6, frame height in pixels (>= WIN_H)
WIN_W, 3, window width in pixels (>= 1)
WIN_H, 3, window height in pixels (>= 1)

Ports:
clk  input  1  single clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
datain  input  DW  pixel stream during LOAD
cmd  input  3  command code
cmd_valid  input  1  cmd qualifier
dataout  output  DW  window pixel, registered
output_valid  output  1  dataout qualifier, registered
busy  output  1  high while a command executes; cmd_valid is ignored while high

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: dataout=0, output_valid=0, busy=0, frame memory all 0, mirror=0, state=IDLE.
- Reset origin: ox=(IMG_W-WIN_W+1)/2, oy=(IMG_H-WIN_H+1)/2. For the defaults this is (2,2).
- Reset mid-operation aborts any load or output immediately. No partial state survives.
- Command codes: 0 REFRESH, 1 LOAD, 2 RIGHT (ox+1), 3 LEFT (ox-1), 4 UP (oy-1), 5 DOWN (oy+1), 6 MIRROR (toggle mirror), 7 HOME (origin to reset value, mirror=0).
- Accept rule: a command is accepted at edge E only if cmd_valid=1 and busy=0. busy=1 from E.
- cmd_valid while busy=1 is dropped silently. It is not queued.
- Clamping: ox stays in 0..IMG_W-WIN_W and oy stays in 0..IMG_H-WIN_H. A shift at the limit leaves the origin unchanged and still performs the output burst.
- LOAD: pixel k (k=0..N-1, N=IMG_W*IMG_H, raster order) is sampled from datain at edge E+1+k and written to mem[k].
- LOAD leaves origin and mirror unchanged.
- After the last pixel, LOAD continues into OUT automatically.
- States: IDLE -> LOAD -> OUT -> IDLE for cmd 1. IDLE -> OUT -> IDLE for all other commands.
- OUT: M=WIN_W*WIN_H pixels. Pixel p (row r=p/WIN_W, col c=p%WIN_W) is presented with output_valid=1 after edge S+p.
  - S=E+1 for non-load commands; S=E+N+1 for LOAD.
  - Address = (oy+r)*IMG_W + (ox+c) when mirror=0.
  - Address = (oy+r)*IMG_W + (ox+WIN_W-1-c) when mirror=1.
  - Origin and mirror updates from the accepted command take effect for the same burst.
- Completion: after edge S+M, output_valid=0, dataout=0 and busy=0. A new command may be accepted at edge S+M+1 or later.
- Counters and addresses use $clog2-derived widths, with a minimum of 1 bit. The address is computed without overflow for any legal parameter set.

Optional Feature:
- Macro: LCD_WIN_CMDERR_EN.
- Defined: adds output port cmd_err (1 bit, reset 0). cmd_err pulses high for exactly one cycle, after the edge at which cmd_valid=1 is seen while busy=1.
- Undefined: the port is absent, and dropped commands are fully silent. All other behaviour is identical in both builds.

Decomposition:
- Package lcd_win_pkg holds:
  - cmd code localparams/enum (REFRESH..HOME)
  - state enum (IDLE, LOAD, OUT)
  - the clog2-width helper
- One sub-module, lcd_frame_mem: a parametrised single-write, single-read register array of IMG_W*IMG_H x DW with asynchronous active-low clear.
- Command decoding, origin/mirror registers, counters and the FSM stay in lcd_win_ctrl.

Test Plan:
- Defaults, LOAD with datain=k for k=0..35 -> after 36 sample cycles, 9 valid pixels 14,15,16,20,21,22,26,27,28; busy falls after the 9th.
- RIGHT twice, then REFRESH -> the second RIGHT clamps at ox=3; each burst reads 15,16,17,21,22,23,27,28,29.
- MIRROR, then UP three times -> mirror burst 17,16,15,23,22,21,29,28,27; UP clamps at oy=0, giving 5,4,3,11,10,9,17,16,15.
- HOME -> origin (2,2), mirror off: 14,15,16,20,21,22,26,27,28. Assert cmd_valid=1 during busy -> command ignored (with LCD_WIN_CMDERR_EN, a one-cycle cmd_err pulse).
- Assert reset low mid-LOAD at pixel 10 -> outputs 0 immediately. A subsequent REFRESH outputs 0s except stored pixels are cleared, so all nine pixels are 0.
- Parameter set IMG_W=8, IMG_H=5, WIN_W=4, WIN_H=2, LOAD k -> home (2,2) burst 18,19,20,21,26,27,28,29.
